// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU opcodes, operand-2 source encodings and ALU FSM states.
package cpu_pkg;

    localparam logic [7:0] OP_ADD  = 8'd0;
    localparam logic [7:0] OP_ADDI = 8'd1;
    localparam logic [7:0] OP_SUB  = 8'd2;
    localparam logic [7:0] OP_MUL  = 8'd3;
    localparam logic [7:0] OP_DIV  = 8'd4;
    localparam logic [7:0] OP_SLL  = 8'd5;
    localparam logic [7:0] OP_SRL  = 8'd6;
    localparam logic [7:0] OP_AND  = 8'd7;
    localparam logic [7:0] OP_OR   = 8'd8;
    localparam logic [7:0] OP_NOT  = 8'd9;
    localparam logic [7:0] OP_XOR  = 8'd10;
    localparam logic [7:0] OP_LUI  = 8'd11;

    localparam logic [1:0] OP2_RS2   = 2'b00;
    localparam logic [1:0] OP2_IMM_U = 2'b01;
    localparam logic [1:0] OP2_IMM_I = 2'b10;
    localparam logic [1:0] OP2_ZERO  = 2'b11;

    typedef logic [1:0] alu_state_t;
    localparam alu_state_t ST_IDLE    = 2'd0;
    localparam alu_state_t ST_DIV_RUN = 2'd1;
    localparam alu_state_t ST_DIV_FIX = 2'd2;

endpackage

// File: rtl/div_iter.sv
// Unsigned restoring divider, one quotient bit per clock; valid pulses with the final bit.
module div_iter #(
    parameter int XLEN  = 32,
    parameter int ITERS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient,
    output logic            valid
);
    localparam int LW = $clog2(ITERS + 1);

    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] dvs;
    logic [LW-1:0]   left;
    logic [XLEN:0]   rem_sh;
    logic            fits;

    // Partial remainder shifted left with the next dividend bit pulled from the quotient register.
    assign rem_sh = {rem, quotient[XLEN-1]};
    assign fits   = rem_sh >= {1'b0, dvs};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem      <= '0;
            dvs      <= '0;
            quotient <= '0;
            left     <= '0;
            valid    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (start) begin
                rem      <= '0;
                dvs      <= divisor;
                quotient <= dividend;
                left     <= LW'(ITERS);
            end else if (left != '0) begin
                rem      <= fits ? XLEN'(rem_sh - {1'b0, dvs}) : rem_sh[XLEN-1:0];
                quotient <= {quotient[XLEN-2:0], fits};
                left     <= left - 1'b1;
                valid    <= (left == LW'(1));
            end
        end
    end

endmodule

// File: rtl/alu.sv
// CPU execution unit: single-cycle arithmetic/logic ops plus an iterative signed divide.
// state   | meaning
// IDLE    | waiting for alu_en; single-cycle ops complete here
// DIV_RUN | divider iterating on operand magnitudes
// DIV_FIX | apply quotient sign / special cases, write result, pulse done
module alu
    import cpu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int DIV_ITERS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_en,
    input  logic [7:0]      alu_op,
    input  logic [1:0]      op2_dir,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic            done
);
    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(DIV_ITERS);

    alu_state_t      state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] comb_res;
    logic [XLEN-1:0] op1_mag;
    logic [XLEN-1:0] op2_mag;
    logic [XLEN-1:0] div_q;
    logic            div_valid;
    logic            div_start;
    logic            neg_q;
    logic            dvs_zero;
    logic            unused_ok;

    assign op1       = rs1_data;
    assign unused_ok = &{1'b0, instr[11:0]};

    always_comb begin
        case (op2_dir)
            OP2_RS2:   op2 = rs2_data;
            OP2_IMM_I: op2 = XLEN'($signed(instr[31:20]));
            OP2_IMM_U: op2 = XLEN'({instr[31:12], 12'b0});
            default:   op2 = '0;
        endcase
    end

    always_comb begin
        case (alu_op)
            OP_ADD, OP_ADDI: comb_res = op1 + op2;
            OP_SUB:          comb_res = op1 - op2;
            OP_MUL:          comb_res = op1 * op2;
            OP_SLL:          comb_res = op1 << op2[SHW-1:0];
            OP_SRL:          comb_res = op1 >> op2[SHW-1:0];
            OP_AND:          comb_res = op1 & op2;
            OP_OR:           comb_res = op1 | op2;
            OP_XOR:          comb_res = op1 ^ op2;
            OP_NOT:          comb_res = ~op1;
            OP_LUI:          comb_res = op2;
            default:         comb_res = '0;
        endcase
    end

    assign op1_mag   = op1[XLEN-1] ? -op1 : op1;
    assign op2_mag   = op2[XLEN-1] ? -op2 : op2;
    assign div_start = (state == ST_IDLE) && alu_en && (alu_op == OP_DIV);
    assign busy      = (state != ST_IDLE);

    div_iter #(.XLEN(XLEN), .ITERS(DIV_ITERS)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (op1_mag),
        .divisor  (op2_mag),
        .quotient (div_q),
        .valid    (div_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            result   <= '0;
            done     <= 1'b0;
            neg_q    <= 1'b0;
            dvs_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (div_start) begin
                        neg_q    <= op1[XLEN-1] ^ op2[XLEN-1];
                        dvs_zero <= (op2 == '0);
                        cnt      <= '0;
                        state    <= ST_DIV_RUN;
                    end else if (alu_en) begin
                        result <= comb_res;
                        done   <= 1'b1;
                    end
                end
                ST_DIV_RUN: begin
                    if (cnt == CW'(DIV_ITERS - 1)) begin
                        cnt   <= '0;
                        state <= ST_DIV_FIX;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DIV_FIX: begin
                    // Most-negative / -1 needs no special path: its negated magnitude wraps back to itself.
                    if (dvs_zero)       result <= '1;
                    else if (div_valid) result <= neg_q ? -div_q : div_q;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu with a result scoreboard and immediate-assertion checks.
module tb_alu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        alu_en = 1'b0;
    logic [7:0]  alu_op = 8'd0;
    logic [1:0]  op2_dir = 2'b00;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [31:0] instr = '0;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;
    logic [31:0] sb_q[$];

    typedef struct {
        logic [7:0]  op;
        logic [1:0]  dir;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ins;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    alu dut (
        .clk      (clk),
        .rst      (rst),
        .alu_en   (alu_en),
        .alu_op   (alu_op),
        .op2_dir  (op2_dir),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .instr    (instr),
        .result   (result),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [7:0] op, input logic [1:0] dir, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ins, input logic [31:0] exp);
        @(negedge clk);
        alu_op = op; op2_dir = dir; rs1_data = a; rs2_data = b; instr = ins;
        alu_en = 1'b1;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        alu_en = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max, output int cyc);
        logic [31:0] exp;
        cyc = 0;
        while (done !== 1'b1 && cyc < max) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_done_seen"}, {31'b0, done}, 32'd1);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
        end else begin
            exp = sb_q.pop_front();
            chk({tag, "_result"}, result, exp);
        end
    endtask

    initial begin
        int cyc;
        int k;
        int busy_cnt;
        int overlap;

        vecs[0]  = '{8'd0,  2'b00, 32'd5,        32'd7,        32'h0,        32'd12};
        vecs[1]  = '{8'd1,  2'b10, 32'd10,       32'h0,        32'hFFF00000, 32'd9};
        vecs[2]  = '{8'd11, 2'b01, 32'h0,        32'h0,        32'h12345678, 32'h12345000};
        vecs[3]  = '{8'd5,  2'b00, 32'd1,        32'd33,       32'h0,        32'd2};
        vecs[4]  = '{8'd2,  2'b00, 32'd3,        32'd5,        32'h0,        32'hFFFFFFFE};
        vecs[5]  = '{8'd3,  2'b00, 32'h00010001, 32'h00010001, 32'h0,        32'h00020001};
        vecs[6]  = '{8'd6,  2'b00, 32'h80000000, 32'd31,       32'h0,        32'd1};
        vecs[7]  = '{8'd7,  2'b00, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'hF000F000};
        vecs[8]  = '{8'd8,  2'b00, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'hFFF0FFF0};
        vecs[9]  = '{8'd10, 2'b00, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'h0FF00FF0};
        vecs[10] = '{8'd9,  2'b00, 32'h12345678, 32'hFFFFFFFF, 32'h0,        32'hEDCBA987};
        vecs[11] = '{8'd12, 2'b00, 32'd5,        32'd7,        32'h0,        32'd0};
        vecs[12] = '{8'd0,  2'b11, 32'd5,        32'd7,        32'h0,        32'd5};
        vecs[13] = '{8'd1,  2'b10, 32'd0,        32'h0,        32'h80000000, 32'hFFFFF800};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", result, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single-cycle ops: done right after the start edge, gone one edge later.
        foreach (vecs[i]) begin
            start(vecs[i].op, vecs[i].dir, vecs[i].a, vecs[i].b, vecs[i].ins, vecs[i].exp);
            chk($sformatf("op%0d_busy", i), {31'b0, busy}, 32'd0);
            wait_done($sformatf("op%0d", i), 5, cyc);
            chk($sformatf("op%0d_latency", i), cyc, 0);
            @(posedge clk);
            #1;
            chk($sformatf("op%0d_done_drop", i), {31'b0, done}, 32'd0);
        end

        // DIV -7/2 with a retrigger and operand changes while in flight.
        start(8'd4, 2'b00, 32'hFFFFFFF9, 32'd2, 32'h0, 32'hFFFFFFFD);
        rs1_data = 32'd100;
        rs2_data = 32'd3;
        k = 0;
        busy_cnt = 0;
        overlap = 0;
        while (done !== 1'b1 && k < 100) begin
            if (busy === 1'b1) busy_cnt++;
            @(negedge clk);
            alu_en = (k == 4);
            @(posedge clk);
            #1;
            k++;
        end
        alu_en = 1'b0;
        if (busy === 1'b1 && done === 1'b1) overlap = 1;
        chk("div_latency", k, 33);
        chk("div_busy_cycles", busy_cnt, 33);
        chk("div_busy_done_overlap", overlap, 0);
        chk("div_busy_after_done", {31'b0, busy}, 32'd0);
        wait_done("div_neg", 0, cyc);

        start(8'd4, 2'b00, 32'd7, 32'd0, 32'h0, 32'hFFFFFFFF);
        wait_done("div_by_zero", 60, cyc);
        chk("div_by_zero_latency", cyc, 33);

        start(8'd4, 2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
        wait_done("div_overflow", 60, cyc);
        chk("div_overflow_latency", cyc, 33);

        // Reset ten edges into a DIV; the scoreboard entry is abandoned.
        start(8'd4, 2'b00, 32'd100, 32'd7, 32'h0, 32'd14);
        repeat (9) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        sb_q.delete();
        chk("rst_mid_div_busy", {31'b0, busy}, 32'd0);
        chk("rst_mid_div_done", {31'b0, done}, 32'd0);
        chk("rst_mid_div_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        start(8'd0, 2'b00, 32'd3, 32'd4, 32'h0, 32'd7);
        wait_done("add_after_rst", 5, cyc);
        chk("add_after_rst_latency", cyc, 0);
        chk("sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
